// File: rtl/conv_pkg.sv
// Shared definitions for the systolic convolution chain: default sizes,
// the sample type used by the feeder and the convolution blocks, and the
// feeder's state encoding.
package conv_pkg;

  localparam int N_BITS = 4;
  localparam int DEPTH  = 16;
  localparam int TAPS   = 2;

  typedef logic [N_BITS-1:0] sample_t;

  // ST_ prefix keeps the DONE state distinct from the DONE output port.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_FLUSH,
    ST_DONE
  } feeder_state_t;

endpackage

// File: rtl/sample_buffer.sv
// Frame storage for the sample feeder: DEPTH x N_BITS register file with
// one synchronous write port and one registered read port. Storage is not
// reset; the valid region is tracked by the owner's sample count.
module sample_buffer #(
  parameter int N_BITS = 4,
  parameter int DEPTH  = 16,
  parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [N_BITS-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [N_BITS-1:0] rd_data
);

  logic [N_BITS-1:0] mem_q [DEPTH];
  logic [N_BITS-1:0] mem_d [DEPTH];
  logic [N_BITS-1:0] rd_data_q;
  logic [N_BITS-1:0] rd_data_d;

  // Next contents of the array: unchanged except for the written entry.
  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_addr] = wr_data;
    end
    rd_data_d = mem_q[rd_addr];
  end

  // Storage and read register update every edge; no reset by design.
  always_ff @(posedge clk) begin
    mem_q     <= mem_d;
    rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/conv_sample_feeder.sv
// Upstream sample source for the convolution chain. Buffers one frame from
// the load port, then on START streams it onto X one sample per clock,
// followed by TAPS-1 zeros that drain the chain, then pulses DONE.
// The FSM runs one cycle ahead of the registered X outputs: each state
// cycle issues a buffer read (or a zero) that appears on X after the edge.
module conv_sample_feeder #(
  parameter int N_BITS = conv_pkg::N_BITS,
  parameter int DEPTH  = conv_pkg::DEPTH,
  parameter int TAPS   = conv_pkg::TAPS
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       LD_VALID,
  output logic                       LD_READY,
  input  logic [N_BITS-1:0]          LD_DATA,
  input  logic                       LD_LAST,
  input  logic                       CLR,
  input  logic                       START,
  output logic [N_BITS-1:0]          X,
  output logic                       X_VALID,
  output logic                       BUSY,
  output logic                       DONE,
  output logic [$clog2(DEPTH+1)-1:0] COUNT
);

  import conv_pkg::*;

  localparam int AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW         = $clog2(DEPTH + 1);
  localparam int FW         = (TAPS > 2) ? $clog2(TAPS) : 1;
  localparam int FLUSH_LAST = (TAPS > 1) ? (TAPS - 2) : 0;

  feeder_state_t     state_q, state_d;
  logic [CW-1:0]     count_q, count_d;
  logic              closed_q, closed_d;
  logic [CW-1:0]     idx_q, idx_d;
  logic [FW-1:0]     flush_q, flush_d;
  logic              x_valid_q, x_valid_d;
  logic              x_frame_q, x_frame_d;
  logic              done_q, done_d;
  logic              idle_ok;
  logic              wr_en;
  logic [N_BITS-1:0] rd_data;

  // The DONE pulse cycle is treated as still finishing, so START/CLR/loads
  // are only honoured once it has passed.
  always_comb begin
    idle_ok  = (state_q == ST_IDLE) && !done_q;
    LD_READY = idle_ok && !closed_q && (count_q < CW'(DEPTH)) && !RST;
    wr_en    = LD_VALID && LD_READY && !CLR;
  end

  sample_buffer #(
    .N_BITS (N_BITS),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_buffer (
    .clk     (CLK),
    .wr_en   (wr_en),
    .wr_addr (count_q[AW-1:0]),
    .wr_data (LD_DATA),
    .rd_addr (idx_q[AW-1:0]),
    .rd_data (rd_data)
  );

  // Next-state, frame bookkeeping and the next values of the X-side flags.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    closed_d  = closed_q;
    idx_d     = idx_q;
    flush_d   = flush_q;
    x_valid_d = 1'b0;
    x_frame_d = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (idle_ok) begin
          if (CLR) begin
            count_d  = '0;
            closed_d = 1'b0;
          end else if (START && closed_q && (count_q != '0)) begin
            state_d = ST_STREAM;
            idx_d   = '0;
          end else if (wr_en) begin
            count_d  = count_q + CW'(1);
            closed_d = LD_LAST || (count_q == CW'(DEPTH - 1));
          end
        end
      end
      ST_STREAM: begin
        x_valid_d = 1'b1;
        x_frame_d = 1'b1;
        idx_d     = idx_q + CW'(1);
        if (idx_q == count_q - CW'(1)) begin
          flush_d = '0;
          state_d = (TAPS > 1) ? ST_FLUSH : ST_DONE;
        end
      end
      ST_FLUSH: begin
        x_valid_d = 1'b1;
        flush_d   = flush_q + FW'(1);
        if (flush_q == FW'(FLUSH_LAST)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset; reset abandons any stream.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      closed_q  <= 1'b0;
      idx_q     <= '0;
      flush_q   <= '0;
      x_valid_q <= 1'b0;
      x_frame_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      closed_q  <= closed_d;
      idx_q     <= idx_d;
      flush_q   <= flush_d;
      x_valid_q <= x_valid_d;
      x_frame_q <= x_frame_d;
      done_q    <= done_d;
    end
  end

  // X is zero unless a frame sample is being presented, so the chain sees
  // zeros during flush and while idle.
  always_comb begin
    X       = x_frame_q ? rd_data : '0;
    X_VALID = x_valid_q;
    BUSY    = x_valid_q;
    DONE    = done_q;
    COUNT   = count_q;
  end

endmodule

// File: tb/tb_conv_sample_feeder.sv
// Self-checking bench for conv_sample_feeder: a queue-based frame model
// predicts the X stream; a negedge monitor pops and compares every X_VALID.
module tb_conv_sample_feeder;

  localparam int N_BITS = 4;
  localparam int DEPTH  = 16;
  localparam int TAPS   = 2;
  localparam int CW     = $clog2(DEPTH + 1);

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              LD_VALID = 1'b0;
  logic              LD_READY;
  logic [N_BITS-1:0] LD_DATA = '0;
  logic              LD_LAST = 1'b0;
  logic              CLR = 1'b0;
  logic              START = 1'b0;
  logic [N_BITS-1:0] X;
  logic              X_VALID;
  logic              BUSY;
  logic              DONE;
  logic [CW-1:0]     COUNT;

  int errors = 0;
  int checks = 0;
  int exp_q[$];
  int observed[$];
  int model_buf[$];
  bit model_closed = 1'b0;
  int conv_exp[6] = '{1, 4, 6, 5, 3, 2};
  int frame_a[5]  = '{1, 2, 2, 1, 1};

  always #5 CLK = ~CLK;

  conv_sample_feeder #(
    .N_BITS (N_BITS),
    .DEPTH  (DEPTH),
    .TAPS   (TAPS)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .LD_VALID (LD_VALID),
    .LD_READY (LD_READY),
    .LD_DATA  (LD_DATA),
    .LD_LAST  (LD_LAST),
    .CLR      (CLR),
    .START    (START),
    .X        (X),
    .X_VALID  (X_VALID),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .COUNT    (COUNT)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic applyStimulus(input bit v, input int d, input bit l, input bit c, input bit s);
    LD_VALID = v;
    LD_DATA  = N_BITS'(d);
    LD_LAST  = l;
    CLR      = c;
    START    = s;
    step();
  endtask

  task automatic loadBeat(input int d, input bit last);
    bit rdy;
    rdy = !model_closed && (model_buf.size() < DEPTH);
    LD_VALID = 1'b1;
    LD_DATA  = N_BITS'(d);
    LD_LAST  = last;
    checkOutput("ld_ready", LD_READY, int'(rdy));
    step();
    if (rdy) begin
      model_buf.push_back(d & ((1 << N_BITS) - 1));
      if (last || model_buf.size() == DEPTH) model_closed = 1'b1;
    end
    LD_VALID = 1'b0;
    LD_LAST  = 1'b0;
  endtask

  task automatic clrFrame();
    applyStimulus(0, 0, 0, 1, 0);
    CLR = 1'b0;
    model_buf.delete();
    model_closed = 1'b0;
    checkOutput("count_after_clr", COUNT, 0);
    checkOutput("ld_ready_after_clr", LD_READY, 1);
  endtask

  // Streams the buffered frame; optionally pokes loads and CLR mid-stream.
  task automatic runFrame(input bit poke);
    int n;
    n = model_buf.size();
    foreach (model_buf[i]) exp_q.push_back(model_buf[i]);
    for (int i = 0; i < TAPS - 1; i++) exp_q.push_back(0);
    applyStimulus(0, 0, 0, 0, 1);
    START = 1'b0;
    for (int i = 1; i <= n + TAPS - 1; i++) begin
      if (poke && i <= 3) begin
        LD_VALID = 1'b1;
        LD_DATA  = N_BITS'($urandom);
        CLR      = 1'b1;
        checkOutput("ld_ready_busy", LD_READY, 0);
      end else begin
        LD_VALID = 1'b0;
        CLR      = 1'b0;
      end
      step();
      checkOutput("busy_stream", BUSY, 1);
      checkOutput("x_valid_stream", X_VALID, 1);
      checkOutput("done_early", DONE, 0);
    end
    LD_VALID = 1'b0;
    CLR      = 1'b0;
    step();
    checkOutput("done_pulse", DONE, 1);
    checkOutput("busy_at_done", BUSY, 0);
    checkOutput("x_valid_at_done", X_VALID, 0);
    checkOutput("x_at_done", X, 0);
    applyStimulus(0, 0, 0, 0, 1);
    START = 1'b0;
    checkOutput("done_cleared", DONE, 0);
    step();
    checkOutput("start_in_done_ignored", BUSY, 0);
    checkOutput("count_retained", COUNT, n);
    checkOutput("scoreboard_drained", exp_q.size(), 0);
  endtask

  // Scoreboard monitor: every valid X must match the next predicted sample.
  always @(negedge CLK) begin
    if (!RST) begin
      if (X_VALID) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL sb_underflow: got X=%0d, expected no sample at %0t", X, $time);
        end else begin
          checkOutput("x_sample", X, exp_q.pop_front());
        end
        observed.push_back(int'(X));
      end else begin
        checkOutput("x_idle_zero", X, 0);
      end
    end
  end

  // Main stimulus sequence.
  initial begin
    int len;
    int y;
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("ld_ready_in_reset", LD_READY, 0);
    step();
    RST = 1'b0;
    #1;
    checkOutput("reset_x", X, 0);
    checkOutput("reset_x_valid", X_VALID, 0);
    checkOutput("reset_busy", BUSY, 0);
    checkOutput("reset_done", DONE, 0);
    checkOutput("reset_count", COUNT, 0);
    checkOutput("reset_ld_ready", LD_READY, 1);

    $display("[TB] directed frame 1,2,2,1,1");
    for (int i = 0; i < 5; i++) loadBeat(frame_a[i], i == 4);
    checkOutput("count_frame_a", COUNT, 5);
    checkOutput("ld_ready_closed", LD_READY, 0);
    observed.delete();
    runFrame(0);
    checkOutput("observed_len", observed.size(), 6);
    for (int i = 0; i < 6 && i < observed.size(); i++) begin
      y = observed[i] + 2 * ((i > 0) ? observed[i-1] : 0);
      checkOutput($sformatf("conv_y%0d", i), y, conv_exp[i]);
    end
    $display("[TB] replay after DONE");
    runFrame(0);

    $display("[TB] START ignored on open frame and empty buffer");
    clrFrame();
    for (int i = 0; i < 3; i++) loadBeat(int'($urandom_range(0, 15)), 0);
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("start_open_busy", BUSY, 0);
    checkOutput("start_open_count", COUNT, 3);
    clrFrame();
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("start_empty_busy", BUSY, 0);

    $display("[TB] CLR and START together");
    for (int i = 0; i < 4; i++) loadBeat(int'($urandom_range(0, 15)), i == 3);
    applyStimulus(0, 0, 0, 1, 1);
    model_buf.delete();
    model_closed = 1'b0;
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("clr_start_busy", BUSY, 0);
    checkOutput("clr_start_count", COUNT, 0);
    checkOutput("clr_start_ld_ready", LD_READY, 1);

    $display("[TB] overfill to auto-close, then stream with pokes");
    clrFrame();
    for (int i = 0; i < 20; i++) loadBeat(int'($urandom_range(0, 15)), 0);
    checkOutput("count_full", COUNT, DEPTH);
    runFrame(1);

    $display("[TB] random frames");
    for (int f = 0; f < 4; f++) begin
      clrFrame();
      len = int'($urandom_range(1, DEPTH));
      for (int i = 0; i < len; i++) loadBeat(int'($urandom), i == len - 1);
      checkOutput("count_random", COUNT, len);
      runFrame(0);
    end

    $display("[TB] reset on third X_VALID cycle");
    clrFrame();
    for (int i = 0; i < 6; i++) loadBeat(int'($urandom_range(0, 15)), i == 5);
    foreach (model_buf[i]) exp_q.push_back(model_buf[i]);
    applyStimulus(0, 0, 0, 0, 1);
    START = 1'b0;
    step();
    step();
    step();
    RST = 1'b1;
    step();
    exp_q.delete();
    model_buf.delete();
    model_closed = 1'b0;
    RST = 1'b0;
    #1;
    checkOutput("rst_mid_x", X, 0);
    checkOutput("rst_mid_x_valid", X_VALID, 0);
    checkOutput("rst_mid_busy", BUSY, 0);
    checkOutput("rst_mid_done", DONE, 0);
    checkOutput("rst_mid_count", COUNT, 0);
    checkOutput("rst_mid_ld_ready", LD_READY, 1);
    for (int i = 0; i < 3; i++) loadBeat(int'($urandom_range(0, 15)), i == 2);
    runFrame(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
